// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM and ALU-control issuer for the multicycle MIPS datapath
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
  state_t st, nx;
  logic [3:0] fctl;
  logic fok;
  assign state = st;
  assign fok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  assign fctl = funct == 6'b100010 ? ALU_SUB :
                funct == 6'b100100 ? ALU_AND :
                funct == 6'b100101 ? ALU_OR  :
                funct == 6'b101010 ? ALU_SLT :
                funct == 6'b100111 ? ALU_NOR : ALU_ADD;
  always_comb begin
    ALUControl = ALU_ADD;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    PCWrite = 1'b0;
    IRWrite = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    illegal = 1'b0;
    nx = FETCH;
    if (!reset)
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
          nx = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          illegal = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
          nx = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
               opcode == OP_R    ? EXECUTE :
               opcode == OP_BEQ  ? BRANCH  :
               opcode == OP_ADDI ? ADDIEX  :
               opcode == OP_J    ? JUMP    : FETCH;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nx = opcode == OP_SW ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
          nx = MEMWB;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUControl = fctl;
          illegal = !fok;
          nx = fok ? ALUWB : FETCH;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUControl = ALU_SUB;
          PCSource = 2'b01;
          PCWrite = zero;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nx = ADDIWB;
        end
        ADDIWB: RegWrite = 1'b1;
        JUMP: begin
          PCSource = 2'b10;
          PCWrite = 1'b1;
        end
        default: nx = FETCH;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) st <= FETCH;
    else st <= nx;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed bench with an instruction-level control model checked every cycle
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic [3:0] ALUControl, state;
  logic ALUSrcA, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst, MemtoReg, illegal;
  logic [1:0] ALUSrcB, PCSource;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef int iq[$];
  localparam logic [17:0] RST_OUT = {4'b0010, 14'b0};
  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [3:0] alu_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
  int cmp = 0, bad = 0;
  int cyc = 0, seq = 0, p_lat = 0, p_seq = 0, rw_cnt = 0, ill_cnt = 0, exp_st = 0;
  logic [3:0] ex_alu = 4'd0;
  logic br_pcw = 1'b0, br_seen = 1'b0;
  iq q;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // {supported, alu code} for a funct value
  function automatic logic [4:0] fdec(input logic [5:0] f);
    fdec = {1'b0, 4'b0010};
    for (int i = 0; i < 6; i++) if (fn_tab[i] == f) fdec = {1'b1, alu_tab[i]};
  endfunction

  // states visited after DECODE for a given instruction
  function automatic iq tail(input logic [5:0] op, input logic [5:0] f);
    logic [4:0] d;
    iq r;
    d = fdec(f);
    case (op)
      6'b100011: r = {2, 3, 4};
      6'b101011: r = {2, 5};
      6'b000100: r.push_back(8);
      6'b001000: r = {9, 10};
      6'b000010: r.push_back(11);
      6'b000000: if (d[4]) r = {6, 7}; else r.push_back(6);
      default: r.delete();
    endcase
    return r;
  endfunction

  function automatic logic [17:0] out_of(input int s, input logic [5:0] op, input logic [5:0] f, input logic z);
    logic [3:0] ac;
    logic [1:0] sb, ps;
    logic [4:0] d;
    logic sa, pw, iw, mr, mw, rw, iod, rd, m2r, il;
    ac = 4'b0010; sb = 2'b00; ps = 2'b00; d = fdec(f);
    {sa, pw, iw, mr, mw, rw, iod, rd, m2r, il} = '0;
    case (s)
      0: begin mr = 1; iw = 1; sb = 2'b01; pw = 1; end
      1: begin
        sb = 2'b11;
        il = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
      end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin sa = 1; ac = d[3:0]; il = !d[4]; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ac = 4'b0110; ps = 2'b01; pw = z; end
      9: begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {ac, sa, sb, ps, pw, iw, mr, mw, rw, iod, rd, m2r, il};
  endfunction

  always @(negedge clk) begin
    logic [17:0] act;
    act = {ALUControl, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite, MemRead, MemWrite,
           RegWrite, IorD, RegDst, MemtoReg, illegal};
    rw_cnt += int'(RegWrite);
    ill_cnt += int'(illegal);
    if (reset) begin
      chk("reset outputs", 32'(act), 32'(RST_OUT));
      q.delete();
      cyc = 0;
      seq = 0;
    end else begin
      if (q.size() == 0) begin
        exp_st = 0;
        q.push_back(1);
      end else begin
        exp_st = q.pop_front();
        if (exp_st == 1) q = tail(opcode, funct);
      end
      chk("state", 32'(state), exp_st);
      chk($sformatf("outputs in state %0d", exp_st), 32'(act), 32'(out_of(exp_st, opcode, funct, zero)));
      if (state == 4'd6) ex_alu = ALUControl;
      if (state == 4'd8) begin br_pcw = PCWrite; br_seen = 1'b1; end
      if (state == 4'd0) begin
        p_lat = cyc;
        p_seq = seq;
        cyc = 1;
        seq = 0;
      end else begin
        cyc++;
        seq = (seq << 4) | int'(state);
      end
    end
  end

  task automatic run(input logic [5:0] op, input logic [5:0] f, input logic z,
                     input int lat, input int sq, input string nm);
    opcode = op;
    funct = f;
    zero = z;
    repeat (lat) @(posedge clk);
    @(negedge clk);
    #1;
    chk({nm, " latency"}, p_lat, lat);
    chk({nm, " path"}, p_seq, sq);
  endtask

  initial begin
    int rw0, ill0;
    logic [3:0] r_alu [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC};
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset PCWrite", 32'(PCWrite), 0);
    chk("reset RegWrite", 32'(RegWrite), 0);
    chk("reset ALUControl", 32'(ALUControl), 32'h2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("first state", 32'(state), 0);
    chk("first PCWrite", 32'(PCWrite), 1);
    chk("first IRWrite", 32'(IRWrite), 1);
    chk("first MemRead", 32'(MemRead), 1);
    for (int i = 0; i < 6; i++) begin
      run(6'b000000, fn_tab[i], 1'b0, 4, 32'h167, "rtype");
      chk("rtype alu", 32'(ex_alu), 32'(r_alu[i]));
    end
    run(6'b100011, 6'd0, 1'b0, 5, 32'h1234, "lw");
    run(6'b101011, 6'd0, 1'b0, 4, 32'h125, "sw");
    br_seen = 1'b0;
    run(6'b000100, 6'd0, 1'b1, 3, 32'h18, "beq taken");
    chk("beq taken PCWrite", 32'({br_seen, br_pcw}), 32'b11);
    br_seen = 1'b0;
    run(6'b000100, 6'd0, 1'b0, 3, 32'h18, "beq not taken");
    chk("beq not taken PCWrite", 32'({br_seen, br_pcw}), 32'b10);
    run(6'b000010, 6'd0, 1'b0, 3, 32'h1B, "j");
    run(6'b001000, 6'd0, 1'b0, 4, 32'h19A, "addi");
    ill0 = ill_cnt;
    run(6'b111111, 6'd0, 1'b0, 2, 32'h1, "bad opcode");
    chk("bad opcode illegal pulses", ill_cnt - ill0, 1);
    ill0 = ill_cnt;
    rw0 = rw_cnt;
    run(6'b000000, 6'b000111, 1'b0, 3, 32'h16, "bad funct");
    chk("bad funct illegal pulses", ill_cnt - ill0, 1);
    chk("bad funct regwrites", rw_cnt - rw0, 0);
    rw0 = rw_cnt;
    opcode = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    chk("reached memread", 32'(state), 3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("after mid reset state", 32'(state), 0);
    chk("after mid reset regwrites", rw_cnt - rw0, 0);
    run(6'b001000, 6'd0, 1'b0, 4, 32'h19A, "addi after reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath, and the issuing end of the ALU interface. Each cycle it decodes the instruction opcode and funct fields and drives the datapath enables, the mux selects and the 4-bit ALUControl code to the ALU. It consumes the ALU `zero` flag to resolve branches. Instructions take 3–5 cycles and share one ALU, one memory port and one register file.

## Interface
- No parameters. Opcodes, funct codes and ALUControl codes are fixed and listed below.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag for the current cycle's operation.
- `ALUControl`  out  4  ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, NOR 1100.
- `ALUSrcA`  out  1  ALU operand A: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite`, `IRWrite`, `MemRead`, `MemWrite`, `RegWrite`  out  1 each  enables.
- `IorD`, `RegDst`, `MemtoReg`  out  1 each  mux selects.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported functs: add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs not listed for a state are 0. ALUControl defaults to 0010.
- FETCH:
  - Drives MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR, R-type → EXECUTE, beq → BRANCH, addi → ADDIEX, j → JUMP.
  - Any other opcode → FETCH with `illegal`=1.
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, ADD. Next state: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: drives MemRead=1, IorD=1. Next state: MEMWB.
- MEMWB: drives RegWrite=1, RegDst=0, MemtoReg=1. Next state: FETCH.
- MEMWRITE: drives MemWrite=1, IorD=1. Next state: FETCH.
- EXECUTE:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUControl from funct.
  - Supported funct → ALUWB.
  - Unsupported funct → ALUControl=0010, `illegal`=1, next state FETCH. No register write occurs.
- ALUWB: drives RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=`zero`.
  - PCWrite is the only Mealy output.
  - Next state: FETCH.
- ADDIEX: drives ALUSrcA=1, ALUSrcB=10, ADD. Next state: ADDIWB.
- ADDIWB: drives RegWrite=1, RegDst=0, MemtoReg=0. Next state: FETCH.
- JUMP: drives PCSource=10, PCWrite=1. Next state: FETCH.
- Unused state codes 12–15: all enables 0, next state FETCH. This applies on reaching them by any means, e.g. an SEU hit or a forced state in simulation.

## Timing
- State register updates on the rising edge of `clk`. Outputs other than `state` are combinational from `state`, `opcode`, `funct` and `zero`.
- While `reset`=1:
  - All enables forced to 0.
  - `illegal`=0, ALUControl=0010, other selects 0.
  - `state` loads 0 (FETCH) at the next edge.
- Deassertion of `reset` also takes effect at a clock edge. The first cycle after deassertion is FETCH with FETCH outputs.
- Reset asserted mid-instruction abandons the instruction. No enable is asserted in any reset cycle.
- Instruction latency, FETCH to next FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal opcode 2, illegal funct 3.
- `opcode` and `funct` must be held stable from DECODE until the return to FETCH. IRWrite is asserted only in FETCH.

## Test plan
- Reset held for 3 cycles:
  - During reset: every enable reads 0 and ALUControl=0010.
  - First cycle after release: `state`=0, PCWrite=1, IRWrite=1, MemRead=1.
- R-type sequence:
  - opcode 000000 with funct 100000, 100010, 100100, 100101, 101010, 100111 in turn.
  - EXECUTE shows ALUControl 0010, 0110, 0000, 0001, 0111, 1100 respectively.
  - ALUWB shows RegWrite=1 and RegDst=1.
  - Each instruction takes 4 cycles.
- lw then sw:
  - lw visits states 0,1,2,3,4. MEMREAD shows IorD=1. MEMWB shows MemtoReg=1.
  - sw visits states 0,1,2,5, with MemWrite=1 only in state 5.
- beq with `zero`=1 then `zero`=0:
  - In BRANCH: PCWrite=1 (zero=1) or 0 (zero=0), PCSource=01, ALUControl=0110.
  - Each takes 3 cycles.
- j and addi:
  - j takes 3 cycles with PCSource=10 in JUMP.
  - addi visits states 0,1,9,10, with ALUSrcB=10 in ADDIEX and RegWrite=1, RegDst=0 in ADDIWB.
- Illegal cases and mid-instruction reset:
  - opcode 111111 → `illegal` pulses in DECODE, then FETCH.
  - R-type with funct 000111 → `illegal` pulses in EXECUTE, RegWrite is never asserted, then FETCH.
  - `reset` asserted in MEMREAD → no MemWB write occurs and the next state is FETCH.
